// File: rtl/core_idu_pipe_pkg.sv
// core_idu_pipe_pkg: shared RV32I decode definitions.
// Holds the major opcode constants, the immediate-format encoding, the reset
// NOP, and a helper that maps an opcode to its immediate format. The IDU and
// any other front-end block (such as a branch predictor) import this package.
package core_idu_pipe_pkg;

  localparam logic [6:0] CPU_OPC_LUI      = 7'b0110111;
  localparam logic [6:0] CPU_OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] CPU_OPC_JAL      = 7'b1101111;
  localparam logic [6:0] CPU_OPC_JALR     = 7'b1100111;
  localparam logic [6:0] CPU_OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] CPU_OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] CPU_OPC_STORE    = 7'b0100011;
  localparam logic [6:0] CPU_OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] CPU_OPC_OP       = 7'b0110011;
  localparam logic [6:0] CPU_OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] CPU_OPC_SYSTEM   = 7'b1110011;

  // ADDI x0,x0,0
  localparam logic [31:0] CPU_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    CPU_IMM_NONE = 3'd0,
    CPU_IMM_I    = 3'd1,
    CPU_IMM_S    = 3'd2,
    CPU_IMM_B    = 3'd3,
    CPU_IMM_U    = 3'd4,
    CPU_IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    case (opc)
      CPU_OPC_LOAD, CPU_OPC_OP_IMM, CPU_OPC_JALR: imm_fmt_of = CPU_IMM_I;
      CPU_OPC_STORE:                              imm_fmt_of = CPU_IMM_S;
      CPU_OPC_BRANCH:                             imm_fmt_of = CPU_IMM_B;
      CPU_OPC_LUI, CPU_OPC_AUIPC:                 imm_fmt_of = CPU_IMM_U;
      CPU_OPC_JAL:                                imm_fmt_of = CPU_IMM_J;
      default:                                    imm_fmt_of = CPU_IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/core_idu_pipe_immgen.sv
// core_idu_immgen: combinational RV32I immediate generator.
// Ports:
//   instr_i  - 32-bit instruction
//   imm_o    - immediate sign-extended from instr[31] to CPU_XLEN bits
//   fmt_o    - immediate format selected from the opcode
// Purely combinational, so it can be shared with a fetch-side predictor.
module core_idu_immgen
  import core_idu_pipe_pkg::*;
#(
  parameter int CPU_XLEN       = 32,
  parameter int CPU_INSTR_SIZE = 32
) (
  input  logic [CPU_INSTR_SIZE-1:0] instr_i,
  output logic [CPU_XLEN-1:0]       imm_o,
  output imm_fmt_e                  fmt_o
);

  logic signed [31:0] imm32;

  assign fmt_o = imm_fmt_of(instr_i[6:0]);

  always_comb begin
    imm32 = '0;
    case (fmt_o)
      CPU_IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      CPU_IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      CPU_IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      CPU_IMM_U: imm32 = {instr_i[31:12], 12'h000};
      CPU_IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
  end

  // Signed size cast widens with sign extension for any CPU_XLEN >= 32.
  assign imm_o = CPU_XLEN'(imm32);

endmodule

// File: rtl/core_idu_pipe.sv
// core_idu_pipe: RV32I decode stage with its own IF/ID register.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   ifu_valid_i/ifu_ready_o         - upstream handshake, pc_i/instr_i payload
//   flush_i                         - kill held instruction, drop incoming
//   rf_rs*_idx_o / rf_rs*_data_i    - combinational regfile read port
//   wb_en_i/wb_idx_i/wb_data_i      - same-cycle write-back for bypass
//   ex_load_i/ex_rsd_idx_i          - load in EX, for load-use stall
//   exu_valid_o/exu_ready_i         - downstream handshake
//   pc_o, instr_o, rs*/rsd idx, rs*_data_o, imm_o, rsd_wen_o, illegal_o
//                                   - decoded payload of the held instruction
module core_idu_pipe
  import core_idu_pipe_pkg::*;
#(
  parameter int CPU_XLEN        = 32,
  parameter int CPU_PC_SIZE     = 32,
  parameter int CPU_INSTR_SIZE  = 32,
  parameter int CPU_RFIDX_WIDTH = 5,
  parameter bit BYPASS_EN       = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ifu_valid_i,
  output logic                       ifu_ready_o,
  input  logic [CPU_PC_SIZE-1:0]     pc_i,
  input  logic [CPU_INSTR_SIZE-1:0]  instr_i,
  input  logic                       flush_i,
  output logic [CPU_RFIDX_WIDTH-1:0] rf_rs1_idx_o,
  output logic [CPU_RFIDX_WIDTH-1:0] rf_rs2_idx_o,
  input  logic [CPU_XLEN-1:0]        rf_rs1_data_i,
  input  logic [CPU_XLEN-1:0]        rf_rs2_data_i,
  input  logic                       wb_en_i,
  input  logic [CPU_RFIDX_WIDTH-1:0] wb_idx_i,
  input  logic [CPU_XLEN-1:0]        wb_data_i,
  input  logic                       ex_load_i,
  input  logic [CPU_RFIDX_WIDTH-1:0] ex_rsd_idx_i,
  output logic                       exu_valid_o,
  input  logic                       exu_ready_i,
  output logic [CPU_PC_SIZE-1:0]     pc_o,
  output logic [CPU_INSTR_SIZE-1:0]  instr_o,
  output logic [CPU_RFIDX_WIDTH-1:0] rs1_idx_o,
  output logic [CPU_RFIDX_WIDTH-1:0] rs2_idx_o,
  output logic [CPU_RFIDX_WIDTH-1:0] rsd_idx_o,
  output logic [CPU_XLEN-1:0]        rs1_data_o,
  output logic [CPU_XLEN-1:0]        rs2_data_o,
  output logic [CPU_XLEN-1:0]        imm_o,
  output logic                       rsd_wen_o,
  output logic                       illegal_o
);

  logic                       valid_q;
  logic [CPU_PC_SIZE-1:0]     pc_q;
  logic [CPU_INSTR_SIZE-1:0]  instr_q;

  logic [6:0]                 opc;
  logic [CPU_RFIDX_WIDTH-1:0] rs1;
  logic [CPU_RFIDX_WIDTH-1:0] rs2;
  logic [CPU_RFIDX_WIDTH-1:0] rsd;
  imm_fmt_e                   fmt;
  logic                       uses_rs1;
  logic                       uses_rs2;
  logic                       writes_rd;
  logic                       known_opc;
  logic                       hazard;
  logic                       fire_out;

  // x0 reads as zero; write-back to x0 is never forwarded since idx==0 wins.
  function automatic logic [CPU_XLEN-1:0] read_opnd(
    input logic [CPU_RFIDX_WIDTH-1:0] idx,
    input logic [CPU_XLEN-1:0]        rf_data,
    input logic                       wb_en,
    input logic [CPU_RFIDX_WIDTH-1:0] wb_idx,
    input logic [CPU_XLEN-1:0]        wb_data
  );
    if (idx == '0)
      read_opnd = '0;
    else if (BYPASS_EN && wb_en && (wb_idx == idx))
      read_opnd = wb_data;
    else
      read_opnd = rf_data;
  endfunction

  // ---- IF/ID register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= CPU_INSTR_SIZE'(CPU_NOP);
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (ifu_valid_i && ifu_ready_o) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (fire_out) begin
      valid_q <= 1'b0;
    end
  end

  // ---- decode of held instruction ----
  assign opc = instr_q[6:0];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign rsd = instr_q[11:7];

  core_idu_immgen #(
    .CPU_XLEN       (CPU_XLEN),
    .CPU_INSTR_SIZE (CPU_INSTR_SIZE)
  ) u_immgen (
    .instr_i (instr_q),
    .imm_o   (imm_o),
    .fmt_o   (fmt)
  );

  // I covers JALR/LOAD/OP-IMM; S and B both read rs1 and rs2; OP has no imm.
  assign uses_rs1 = (fmt == CPU_IMM_I) || (fmt == CPU_IMM_S) ||
                    (fmt == CPU_IMM_B) || (opc == CPU_OPC_OP);
  assign uses_rs2 = (fmt == CPU_IMM_S) || (fmt == CPU_IMM_B) ||
                    (opc == CPU_OPC_OP);

  always_comb begin
    writes_rd = 1'b0;
    known_opc = 1'b0;
    case (opc)
      CPU_OPC_LUI, CPU_OPC_AUIPC, CPU_OPC_JAL, CPU_OPC_JALR,
      CPU_OPC_LOAD, CPU_OPC_OP_IMM, CPU_OPC_OP: begin
        writes_rd = 1'b1;
        known_opc = 1'b1;
      end
      CPU_OPC_BRANCH, CPU_OPC_STORE, CPU_OPC_MISC_MEM, CPU_OPC_SYSTEM:
        known_opc = 1'b1;
      default: ;
    endcase
  end

  assign hazard = valid_q && ex_load_i && (ex_rsd_idx_i != '0) &&
                  ((uses_rs1 && (rs1 == ex_rsd_idx_i)) ||
                   (uses_rs2 && (rs2 == ex_rsd_idx_i)));

  // ---- handshake toward EX and IFU ----
  assign exu_valid_o = valid_q && !hazard && !flush_i;
  assign fire_out    = exu_valid_o && exu_ready_i;
  assign ifu_ready_o = flush_i || !valid_q || fire_out;

  assign rf_rs1_idx_o = rs1;
  assign rf_rs2_idx_o = rs2;
  assign rs1_data_o   = read_opnd(rs1, rf_rs1_data_i, wb_en_i, wb_idx_i, wb_data_i);
  assign rs2_data_o   = read_opnd(rs2, rf_rs2_data_i, wb_en_i, wb_idx_i, wb_data_i);

  assign pc_o      = pc_q;
  assign instr_o   = instr_q;
  assign rs1_idx_o = rs1;
  assign rs2_idx_o = rs2;
  assign rsd_idx_o = rsd;
  assign rsd_wen_o = valid_q && writes_rd && (rsd != '0);
  assign illegal_o = valid_q && ((instr_q[1:0] != 2'b11) || !known_opc);

endmodule

// File: tb/tb_core_idu_pipe.sv
// tb_core_idu_pipe: directed self-checking bench for core_idu_pipe.
// Two instances share all inputs: one with write-back bypass, one without.
module tb_core_idu_pipe;

  logic        clk;
  logic        rst_n;
  logic        ifu_valid_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        flush_i;
  logic [31:0] rf_rs1_data_i;
  logic [31:0] rf_rs2_data_i;
  logic        wb_en_i;
  logic [4:0]  wb_idx_i;
  logic [31:0] wb_data_i;
  logic        ex_load_i;
  logic [4:0]  ex_rsd_idx_i;
  logic        exu_ready_i;

  logic        ifu_ready_o, exu_valid_o, rsd_wen_o, illegal_o;
  logic [4:0]  rf_rs1_idx_o, rf_rs2_idx_o, rs1_idx_o, rs2_idx_o, rsd_idx_o;
  logic [31:0] pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o;

  logic        nb_ifu_ready, nb_exu_valid, nb_rsd_wen, nb_illegal;
  logic [4:0]  nb_rf_rs1_idx, nb_rf_rs2_idx, nb_rs1_idx, nb_rs2_idx, nb_rsd_idx;
  logic [31:0] nb_pc, nb_instr, nb_rs1_data, nb_rs2_data, nb_imm;

  int total = 0;
  int bad   = 0;

  core_idu_pipe #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_valid_i(ifu_valid_i), .ifu_ready_o(ifu_ready_o),
    .pc_i(pc_i), .instr_i(instr_i), .flush_i(flush_i),
    .rf_rs1_idx_o(rf_rs1_idx_o), .rf_rs2_idx_o(rf_rs2_idx_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .wb_en_i(wb_en_i), .wb_idx_i(wb_idx_i), .wb_data_i(wb_data_i),
    .ex_load_i(ex_load_i), .ex_rsd_idx_i(ex_rsd_idx_i),
    .exu_valid_o(exu_valid_o), .exu_ready_i(exu_ready_i),
    .pc_o(pc_o), .instr_o(instr_o),
    .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o), .rsd_idx_o(rsd_idx_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .rsd_wen_o(rsd_wen_o), .illegal_o(illegal_o)
  );

  core_idu_pipe #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .ifu_valid_i(ifu_valid_i), .ifu_ready_o(nb_ifu_ready),
    .pc_i(pc_i), .instr_i(instr_i), .flush_i(flush_i),
    .rf_rs1_idx_o(nb_rf_rs1_idx), .rf_rs2_idx_o(nb_rf_rs2_idx),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .wb_en_i(wb_en_i), .wb_idx_i(wb_idx_i), .wb_data_i(wb_data_i),
    .ex_load_i(ex_load_i), .ex_rsd_idx_i(ex_rsd_idx_i),
    .exu_valid_o(nb_exu_valid), .exu_ready_i(exu_ready_i),
    .pc_o(nb_pc), .instr_o(nb_instr),
    .rs1_idx_o(nb_rs1_idx), .rs2_idx_o(nb_rs2_idx), .rsd_idx_o(nb_rsd_idx),
    .rs1_data_o(nb_rs1_data), .rs2_data_o(nb_rs2_data), .imm_o(nb_imm),
    .rsd_wen_o(nb_rsd_wen), .illegal_o(nb_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ifu_valid_i = 1'b0; pc_i = '0; instr_i = '0; flush_i = 1'b0;
    rf_rs1_data_i = '0; rf_rs2_data_i = '0; wb_en_i = 1'b0; wb_idx_i = '0;
    wb_data_i = '0; ex_load_i = 1'b0; ex_rsd_idx_i = '0; exu_ready_i = 1'b1;

    // Reset state
    tick(); tick(); #1;
    chk("rst_exu_valid", exu_valid_o, 0);
    chk("rst_ifu_ready", ifu_ready_o, 1);
    chk("rst_instr",     instr_o, 32'h0000_0013);
    chk("rst_pc",        pc_o, 0);
    chk("rst_rsd_wen",   rsd_wen_o, 0);
    chk("rst_illegal",   illegal_o, 0);
    chk("rst_imm",       imm_o, 0);

    // Back-to-back ADDI x1,x0,5 then ADD x2,x1,x1
    rst_n = 1'b1;
    tick();
    ifu_valid_i = 1'b1; pc_i = 32'h100; instr_i = 32'h0050_0093;
    #1 chk("b2b_ready_empty", ifu_ready_o, 1);
    tick();
    pc_i = 32'h104; instr_i = 32'h0010_8133;
    #1;
    chk("addi_valid",   exu_valid_o, 1);
    chk("addi_imm",     imm_o, 5);
    chk("addi_pc",      pc_o, 32'h100);
    chk("addi_rsd",     rsd_idx_o, 1);
    chk("addi_wen",     rsd_wen_o, 1);
    chk("addi_ready",   ifu_ready_o, 1);
    tick();
    ifu_valid_i = 1'b0;
    #1;
    chk("add_valid",    exu_valid_o, 1);
    chk("add_imm",      imm_o, 0);
    chk("add_instr",    instr_o, 32'h0010_8133);
    chk("add_rs2_idx",  rs2_idx_o, 1);
    chk("add_ready",    ifu_ready_o, 1);
    tick();
    #1 chk("drain_valid", exu_valid_o, 0);

    // Load-use hazard on SW x1,8(x2)
    ifu_valid_i = 1'b1; pc_i = 32'h200; instr_i = 32'h0011_2423;
    ex_load_i = 1'b1; ex_rsd_idx_i = 5'd1;
    tick();
    pc_i = 32'h20C; instr_i = 32'h0000_0013;
    #1;
    chk("haz_valid",    exu_valid_o, 0);
    chk("haz_ready",    ifu_ready_o, 0);
    chk("haz_imm",      imm_o, 8);
    tick();
    #1;
    chk("haz_hold_instr", instr_o, 32'h0011_2423);
    chk("haz_hold_valid", exu_valid_o, 0);
    ex_rsd_idx_i = 5'd0;
    #1 chk("haz_x0_no_stall", exu_valid_o, 1);
    ex_rsd_idx_i = 5'd1;
    #1 chk("haz_restall", exu_valid_o, 0);
    ex_load_i = 1'b0;
    #1;
    chk("rel_valid",    exu_valid_o, 1);
    chk("rel_ready",    ifu_ready_o, 1);
    chk("rel_imm",      imm_o, 8);
    chk("sw_wen",       rsd_wen_o, 0);
    tick();
    ifu_valid_i = 1'b0;
    #1;
    chk("next_pc",      pc_o, 32'h20C);
    chk("next_valid",   exu_valid_o, 1);
    tick();

    // Bypass on ADD x4,x3,x0, held by exu_ready_i=0
    exu_ready_i = 1'b0;
    ifu_valid_i = 1'b1; pc_i = 32'h400; instr_i = 32'h0001_8233;
    tick();
    ifu_valid_i = 1'b0;
    wb_en_i = 1'b1; wb_idx_i = 5'd3; wb_data_i = 32'hDEAD_BEEF;
    rf_rs1_data_i = '0; rf_rs2_data_i = '0;
    #1;
    chk("byp_rf_idx",   rf_rs1_idx_o, 3);
    chk("byp_rs1",      rs1_data_o, 32'hDEAD_BEEF);
    chk("byp_rs2",      rs2_data_o, 0);
    chk("nobyp_rs1",    nb_rs1_data, 0);
    chk("stall_valid",  exu_valid_o, 1);
    chk("stall_ready",  ifu_ready_o, 0);
    rf_rs1_data_i = 32'h1111_2222;
    #1 chk("nobyp_rf",  nb_rs1_data, 32'h1111_2222);
    wb_idx_i = 5'd0; rf_rs2_data_i = 32'h0000_1234;
    #1;
    chk("x0_no_byp",    rs2_data_o, 0);
    chk("byp_miss_rf",  rs1_data_o, 32'h1111_2222);
    wb_idx_i = 5'd3; ex_load_i = 1'b1; ex_rsd_idx_i = 5'd3;
    #1 chk("haz_beats_byp", exu_valid_o, 0);

    // Flush during hazard stall, with an incoming instruction
    flush_i = 1'b1; ifu_valid_i = 1'b1; pc_i = 32'h300; instr_i = 32'h0050_0093;
    #1;
    chk("flush_ready",  ifu_ready_o, 1);
    chk("flush_valid",  exu_valid_o, 0);
    tick();
    flush_i = 1'b0; ifu_valid_i = 1'b0; ex_load_i = 1'b0; wb_en_i = 1'b0;
    #1;
    chk("flushed_valid", exu_valid_o, 0);
    chk("flushed_pc",    pc_o, 32'h400);
    chk("flushed_instr", instr_o, 32'h0001_8233);
    chk("flushed_ready", ifu_ready_o, 1);

    // Immediate formats and illegal encoding
    exu_ready_i = 1'b1;
    ifu_valid_i = 1'b1; pc_i = 32'h500; instr_i = 32'hFE00_0EE3;
    tick();
    pc_i = 32'h504; instr_i = 32'h0000_0000;
    #1;
    chk("beq_imm",      imm_o, 32'hFFFF_FFFC);
    chk("beq_wen",      rsd_wen_o, 0);
    chk("beq_illegal",  illegal_o, 0);
    tick();
    pc_i = 32'h508; instr_i = 32'h1234_52B7;
    #1;
    chk("ill_flag",     illegal_o, 1);
    chk("ill_valid",    exu_valid_o, 1);
    chk("ill_wen",      rsd_wen_o, 0);
    tick();
    pc_i = 32'h50C; instr_i = 32'h0080_00EF;
    #1;
    chk("lui_imm",      imm_o, 32'h1234_5000);
    chk("lui_wen",      rsd_wen_o, 1);
    tick();
    ifu_valid_i = 1'b0;
    #1;
    chk("jal_imm",      imm_o, 8);
    chk("jal_valid",    exu_valid_o, 1);

    // Asynchronous reset mid-stream while an instruction is held
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",   exu_valid_o, 0);
    chk("arst_instr",   instr_o, 32'h0000_0013);
    chk("arst_ready",   ifu_ready_o, 1);
    chk("arst_pc",      pc_o, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
